// File: rtl/ibex_fetch_req_sched.sv
// ---------------------------------------------------------------------------
// ibex_fetch_req_sched
//
// Request scheduler placed in front of ibex_fetch_fifo. It issues word-aligned
// instruction-bus requests only while the FIFO can absorb every outstanding
// response. It tracks up to NUM_REQS granted-but-unanswered requests and
// forwards their in-order responses into the FIFO input port. On a branch it
// clears the FIFO, redirects the fetch address and marks every in-flight
// response (including a request still waiting for its grant) as stale, so
// those responses are dropped when they return.
//
// Parameters
//   NUM_REQS        max outstanding bus requests (>= 1, equal to the FIFO's)
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   req_i           fetch enable; 0 stops new requests, responses still drain
//   branch_i        single-cycle redirect strobe
//   branch_addr_i   redirect target, bits [1:0] ignored
//   fifo_busy_i     FIFO busy_o; bit k=1 means the FIFO cannot take k+1 words
//   fifo_clear_o    FIFO clear_i
//   fifo_valid_o    FIFO in_valid_i
//   fifo_addr_o     FIFO in_addr_i
//   fifo_rdata_o    FIFO in_rdata_i
//   fifo_err_o      FIFO in_err_i
//   instr_req_o     bus request
//   instr_addr_o    bus address, always word aligned
//   instr_gnt_i     bus grant
//   instr_rvalid_i  bus response valid
//   instr_rdata_i   bus response data
//   instr_err_i     bus response error
//   busy_o          1 while any request is outstanding or waiting for grant
// ---------------------------------------------------------------------------
module ibex_fetch_req_sched #(
   parameter int unsigned NUM_REQS = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         branch_addr_i,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_clear_o,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_gnt_i,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i,
   output logic                busy_o
);

   // Counter wide enough to hold 0..NUM_REQS.
   localparam int unsigned CW = $clog2(NUM_REQS + 1);

   typedef enum logic {
      IDLE,
      WAIT_GNT
   } state_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [31:0]         fetch_addr_q, fetch_addr_d;  // next address to issue
   logic [31:0]         resp_addr_q, resp_addr_d;    // address of next kept response
   logic [31:0]         req_addr_q, req_addr_d;      // address held while waiting for grant
   logic [CW-1:0]       out_cnt_q, out_cnt_d;        // granted, awaiting rvalid
   logic [NUM_REQS-1:0] discard_q, discard_d;        // per slot, index 0 = oldest
   logic                req_stale_q, req_stale_d;    // pending request predates a branch

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   // True when cnt < NUM_REQS and the FIFO can accept cnt+1 more words.
   // Written as a compare loop so fifo_busy_i is never indexed out of range.
   function automatic logic slot_free(input logic [CW-1:0]       cnt,
                                      input logic [NUM_REQS-1:0] busy);
      logic free;
      free = 1'b0;
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
         if (cnt == CW'(k)) free = ~busy[k];
      end
      return free;
   endfunction

   // ------------------------------------------------------------------------
   // Combinational datapath
   // ------------------------------------------------------------------------
   logic          issue;          // new request starts from IDLE this cycle
   logic          req_active;     // instr_req_o
   logic          grant;          // request accepted this cycle
   logic          grant_stale;    // accepted request belongs to the old stream
   logic          rvalid_ok;      // response that actually pops a slot
   logic          resp_write;     // response forwarded to the FIFO
   logic          branch_ok;
   logic          reissue;
   logic [CW-1:0] cnt_after_pop;
   logic [31:0]   branch_target;

   // The combinational outputs are gated with rst_ni so every output reads 0
   // while reset is asserted, whatever the inputs are doing.
   assign branch_ok     = rst_ni & branch_i;
   assign issue         = rst_ni & req_i & (state_q == IDLE)
                        & slot_free(out_cnt_q, fifo_busy_i);
   assign req_active    = rst_ni & ((state_q == WAIT_GNT) | issue);
   assign grant         = req_active & instr_gnt_i;
   // A grant that coincides with a branch, or that answers a request issued
   // before the branch, fetches from the old stream.
   assign grant_stale   = branch_i | req_stale_q;
   // rvalid with nothing outstanding is a protocol error and is ignored.
   assign rvalid_ok     = rst_ni & instr_rvalid_i & (out_cnt_q != '0);
   // A response in the branch cycle always belongs to the old stream.
   assign resp_write    = rvalid_ok & ~discard_q[0] & ~branch_i;
   assign branch_target = {branch_addr_i[31:2], 2'b00};

   assign cnt_after_pop = out_cnt_q - CW'(rvalid_ok);

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      resp_addr_d  = resp_addr_q;
      req_addr_d   = req_addr_q;
      req_stale_d  = req_stale_q;
      out_cnt_d    = cnt_after_pop + CW'(grant);
      discard_d    = rvalid_ok ? (discard_q >> 1) : discard_q;

      // Fetch address: a branch overrides everything. A stale grant does not
      // advance, because fetch_addr_q already points at the branch target.
      if (branch_ok) begin
         fetch_addr_d = branch_target;
      end else if (grant && !req_stale_q) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
      end

      // Response address follows the kept responses only.
      if (branch_ok) begin
         resp_addr_d = branch_target;
      end else if (resp_write) begin
         resp_addr_d = resp_addr_q + 32'd4;
      end

      // New slot lands just above the surviving entries after the pop.
      if (grant) begin
         for (int unsigned k = 0; k < NUM_REQS; k++) begin
            if (cnt_after_pop == CW'(k)) discard_d[k] = grant_stale;
         end
      end
      // Everything in flight, including a slot created this cycle, is stale.
      if (branch_ok) discard_d = '1;

      // Re-issue check on grant uses the count as it will be next cycle.
      reissue = req_i & slot_free(out_cnt_d, fifo_busy_i);

      if (grant) begin
         state_d     = reissue ? WAIT_GNT : IDLE;
         req_addr_d  = fetch_addr_d;
         req_stale_d = 1'b0;
      end else if (issue) begin
         state_d     = WAIT_GNT;
         req_addr_d  = fetch_addr_q;
         req_stale_d = branch_ok;
      end else if (req_active && branch_ok) begin
         // Ungranted request stays on the bus with its old address.
         req_stale_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         fetch_addr_q <= '0;
         resp_addr_q  <= '0;
         req_addr_q   <= '0;
         out_cnt_q    <= '0;
         // NOTE: the discard flags form a tiny slot array but are reset anyway;
         // a stale flag surviving reset would silently drop a valid response.
         discard_q    <= '0;
         req_stale_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         resp_addr_q  <= resp_addr_d;
         req_addr_q   <= req_addr_d;
         out_cnt_q    <= out_cnt_d;
         discard_q    <= discard_d;
         req_stale_q  <= req_stale_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign instr_req_o  = req_active;
   // While waiting for grant the address must not move, even across a branch.
   assign instr_addr_o = (state_q == WAIT_GNT) ? req_addr_q : fetch_addr_q;

   assign fifo_clear_o = branch_ok;
   assign fifo_valid_o = resp_write;
   assign fifo_addr_o  = resp_addr_q;
   assign fifo_rdata_o = rst_ni ? instr_rdata_i : '0;
   assign fifo_err_o   = rst_ni & instr_err_i;

   assign busy_o       = (out_cnt_q != '0) | req_active;

   // ------------------------------------------------------------------------
   // Protocol check: a response must always have an outstanding request.
   // ------------------------------------------------------------------------
   rvalid_without_req : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(instr_rvalid_i && (out_cnt_q == '0))
   ) else $error("ibex_fetch_req_sched: rvalid with no outstanding request");

endmodule

// File: tb/tb_ibex_fetch_req_sched.sv
// ---------------------------------------------------------------------------
// tb_ibex_fetch_req_sched
//
// Directed bench for ibex_fetch_req_sched. Each task drives one scenario and
// compares outputs against hand-computed values. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ibex_fetch_req_sched;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic [1:0]  fifo_busy_i;
   logic        fifo_clear_o;
   logic        fifo_valid_o;
   logic [31:0] fifo_addr_o;
   logic [31:0] fifo_rdata_o;
   logic        fifo_err_o;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;
   logic        busy_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   ibex_fetch_req_sched #(.NUM_REQS(2)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .branch_addr_i  (branch_addr_i),
      .fifo_busy_i    (fifo_busy_i),
      .fifo_clear_o   (fifo_clear_o),
      .fifo_valid_o   (fifo_valid_o),
      .fifo_addr_o    (fifo_addr_o),
      .fifo_rdata_o   (fifo_rdata_o),
      .fifo_err_o     (fifo_err_o),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .busy_o         (busy_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      req_i          = 1'b0;
      branch_i       = 1'b0;
      branch_addr_i  = 32'h0;
      fifo_busy_i    = 2'b00;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      instr_err_i    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst_ni         = 1'b0;
      req_i          = 1'b1;
      branch_i       = 1'b1;
      branch_addr_i  = 32'hFFFF_FFFF;
      fifo_busy_i    = 2'b00;
      instr_gnt_i    = 1'b1;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'hDEAD_BEEF;
      instr_err_i    = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b exp 0", instr_req_o); end
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h exp 0", instr_addr_o); end
      n_cmp++; if (fifo_clear_o !== 1'b0) begin n_err++; $display("FAIL rst_clear: got %b exp 0", fifo_clear_o); end
      n_cmp++; if (fifo_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", fifo_valid_o); end
      n_cmp++; if (fifo_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_faddr: got %h exp 0", fifo_addr_o); end
      n_cmp++; if (fifo_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h exp 0", fifo_rdata_o); end
      n_cmp++; if (fifo_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b exp 0", fifo_err_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
      do_reset();
      @(negedge clk_i);
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b exp 0", busy_o); end
      n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL post_rst_req: got %b exp 0", instr_req_o); end
   endtask

   // -------------------------------------------------------------------------
   // Grant tied high, each response one cycle after its grant.
   task automatic test_stream();
      do_reset();
      req_i       = 1'b1;
      instr_gnt_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         instr_rvalid_i = (k > 0);
         instr_rdata_i  = 32'h1000 + 32'(k);
         @(negedge clk_i);
         n_cmp++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL stream_req[%0d]: got %b exp 1", k, instr_req_o); end
         n_cmp++; if (instr_addr_o !== 32'(4 * k)) begin n_err++; $display("FAIL stream_addr[%0d]: got %h exp %h", k, instr_addr_o, 32'(4 * k)); end
         if (k > 0) begin
            n_cmp++; if (fifo_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b exp 1", k, fifo_valid_o); end
            n_cmp++; if (fifo_addr_o !== 32'(4 * (k - 1))) begin n_err++; $display("FAIL stream_faddr[%0d]: got %h exp %h", k, fifo_addr_o, 32'(4 * (k - 1))); end
            n_cmp++; if (fifo_rdata_o !== 32'h1000 + 32'(k)) begin n_err++; $display("FAIL stream_rdata[%0d]: got %h exp %h", k, fifo_rdata_o, 32'h1000 + 32'(k)); end
         end
         step();
      end
      // Fetch disabled while the pending request for 0x18 is granted.
      req_i = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h18) begin n_err++; $display("FAIL stream_last_addr: got %h exp 18", instr_addr_o); end
      n_cmp++; if (fifo_addr_o !== 32'h14) begin n_err++; $display("FAIL stream_last_faddr: got %h exp 14", fifo_addr_o); end
      step();
      instr_gnt_i = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL stream_stop_req: got %b exp 0", instr_req_o); end
      n_cmp++; if (fifo_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_drain_valid: got %b exp 1", fifo_valid_o); end
      n_cmp++; if (fifo_addr_o !== 32'h18) begin n_err++; $display("FAIL stream_drain_faddr: got %h exp 18", fifo_addr_o); end
      step();
      instr_rvalid_i = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL stream_idle_busy: got %b exp 0", busy_o); end
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   // FIFO full: nothing issued; one free word: exactly one request.
   task automatic test_fifo_busy();
      do_reset();
      req_i       = 1'b1;
      instr_gnt_i = 1'b1;
      fifo_busy_i = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL full_req[%0d]: got %b exp 0", k, instr_req_o); end
         step();
      end
      fifo_busy_i = 2'b10;
      @(negedge clk_i);
      n_cmp++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL one_req: got %b exp 1", instr_req_o); end
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL one_addr: got %h exp 0", instr_addr_o); end
      step();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL one_wait_req[%0d]: got %b exp 0", k, instr_req_o); end
         n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL one_wait_busy[%0d]: got %b exp 1", k, busy_o); end
         step();
      end
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'hA5A5_0001;
      @(negedge clk_i);
      n_cmp++; if (fifo_valid_o !== 1'b1) begin n_err++; $display("FAIL one_resp_valid: got %b exp 1", fifo_valid_o); end
      n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL one_resp_req: got %b exp 0", instr_req_o); end
      step();
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   // Two outstanding, branch to 0x1002: both responses dropped.
   task automatic test_branch();
      do_reset();
      req_i       = 1'b1;
      instr_gnt_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL br_addr0: got %h exp 0", instr_addr_o); end
      step();
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h4) begin n_err++; $display("FAIL br_addr1: got %h exp 4", instr_addr_o); end
      step();
      instr_gnt_i   = 1'b0;
      branch_i      = 1'b1;
      branch_addr_i = 32'h1002;
      @(negedge clk_i);
      n_cmp++; if (fifo_clear_o !== 1'b1) begin n_err++; $display("FAIL br_clear: got %b exp 1", fifo_clear_o); end
      n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL br_full_req: got %b exp 0", instr_req_o); end
      n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL br_busy: got %b exp 1", busy_o); end
      step();
      branch_i       = 1'b0;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'h11;
      @(negedge clk_i);
      n_cmp++; if (fifo_valid_o !== 1'b0) begin n_err++; $display("FAIL br_drop0: got %b exp 0", fifo_valid_o); end
      n_cmp++; if (fifo_clear_o !== 1'b0) begin n_err++; $display("FAIL br_clear_off: got %b exp 0", fifo_clear_o); end
      step();
      instr_rdata_i = 32'h22;
      instr_gnt_i   = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (fifo_valid_o !== 1'b0) begin n_err++; $display("FAIL br_drop1: got %b exp 0", fifo_valid_o); end
      n_cmp++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL br_new_req: got %b exp 1", instr_req_o); end
      n_cmp++; if (instr_addr_o !== 32'h1000) begin n_err++; $display("FAIL br_new_addr: got %h exp 1000", instr_addr_o); end
      step();
      instr_rdata_i = 32'h33;
      instr_gnt_i   = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (fifo_valid_o !== 1'b1) begin n_err++; $display("FAIL br_keep_valid: got %b exp 1", fifo_valid_o); end
      n_cmp++; if (fifo_addr_o !== 32'h1000) begin n_err++; $display("FAIL br_keep_faddr: got %h exp 1000", fifo_addr_o); end
      n_cmp++; if (instr_addr_o !== 32'h1004) begin n_err++; $display("FAIL br_next_addr: got %h exp 1004", instr_addr_o); end
      step();
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   // Ungranted request across a branch to 0x200.
   task automatic test_branch_pending();
      do_reset();
      req_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL pend_req: got %b exp 1", instr_req_o); end
      step();
      branch_i      = 1'b1;
      branch_addr_i = 32'h200;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL pend_hold0: got %h exp 0", instr_addr_o); end
      n_cmp++; if (fifo_clear_o !== 1'b1) begin n_err++; $display("FAIL pend_clear: got %b exp 1", fifo_clear_o); end
      step();
      branch_i = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL pend_hold1: got %h exp 0", instr_addr_o); end
      n_cmp++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL pend_hold_req: got %b exp 1", instr_req_o); end
      step();
      instr_gnt_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL pend_gnt_addr: got %h exp 0", instr_addr_o); end
      step();
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'h5555;
      @(negedge clk_i);
      n_cmp++; if (fifo_valid_o !== 1'b0) begin n_err++; $display("FAIL pend_drop: got %b exp 0", fifo_valid_o); end
      n_cmp++; if (instr_addr_o !== 32'h200) begin n_err++; $display("FAIL pend_new_addr: got %h exp 200", instr_addr_o); end
      step();
      instr_gnt_i    = 1'b1;
      instr_rvalid_i = 1'b0;
      step();
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      req_i          = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (fifo_valid_o !== 1'b1) begin n_err++; $display("FAIL pend_keep_valid: got %b exp 1", fifo_valid_o); end
      n_cmp++; if (fifo_addr_o !== 32'h200) begin n_err++; $display("FAIL pend_keep_faddr: got %h exp 200", fifo_addr_o); end
      step();
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   // Error response at 0x40 is forwarded and fetching continues.
   task automatic test_error();
      do_reset();
      branch_i      = 1'b1;
      branch_addr_i = 32'h40;
      step();
      branch_i    = 1'b0;
      req_i       = 1'b1;
      instr_gnt_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h40) begin n_err++; $display("FAIL err_req_addr: got %h exp 40", instr_addr_o); end
      step();
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      instr_err_i    = 1'b1;
      instr_rdata_i  = 32'hBAD0;
      @(negedge clk_i);
      n_cmp++; if (fifo_valid_o !== 1'b1) begin n_err++; $display("FAIL err_valid: got %b exp 1", fifo_valid_o); end
      n_cmp++; if (fifo_err_o !== 1'b1) begin n_err++; $display("FAIL err_flag: got %b exp 1", fifo_err_o); end
      n_cmp++; if (fifo_addr_o !== 32'h40) begin n_err++; $display("FAIL err_faddr: got %h exp 40", fifo_addr_o); end
      n_cmp++; if (fifo_rdata_o !== 32'hBAD0) begin n_err++; $display("FAIL err_rdata: got %h exp bad0", fifo_rdata_o); end
      n_cmp++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL err_next_req: got %b exp 1", instr_req_o); end
      n_cmp++; if (instr_addr_o !== 32'h44) begin n_err++; $display("FAIL err_next_addr: got %h exp 44", instr_addr_o); end
      step();
      instr_gnt_i    = 1'b1;
      instr_rvalid_i = 1'b0;
      instr_err_i    = 1'b0;
      step();
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      req_i          = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (fifo_addr_o !== 32'h44) begin n_err++; $display("FAIL err_after_faddr: got %h exp 44", fifo_addr_o); end
      n_cmp++; if (fifo_err_o !== 1'b0) begin n_err++; $display("FAIL err_after_flag: got %b exp 0", fifo_err_o); end
      step();
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   // Address wrap at 0xFFFFFFFC, then reset mid-flight.
   task automatic test_wrap_reset();
      do_reset();
      branch_i      = 1'b1;
      branch_addr_i = 32'hFFFF_FFFE;
      step();
      branch_i    = 1'b0;
      req_i       = 1'b1;
      instr_gnt_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top: got %h exp fffffffc", instr_addr_o); end
      step();
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h exp 0", instr_addr_o); end
      n_cmp++; if (fifo_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_faddr: got %h exp fffffffc", fifo_addr_o); end
      step();
      instr_gnt_i    = 1'b1;
      instr_rvalid_i = 1'b0;
      step();
      // One request outstanding, another pending: pull reset.
      rst_ni         = 1'b0;
      branch_i       = 1'b1;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'h1234_5678;
      instr_err_i    = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_req: got %b exp 0", instr_req_o); end
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_addr: got %h exp 0", instr_addr_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b exp 0", busy_o); end
      n_cmp++; if (fifo_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b exp 0", fifo_valid_o); end
      n_cmp++; if (fifo_clear_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_clear: got %b exp 0", fifo_clear_o); end
      n_cmp++; if (fifo_rdata_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_rdata: got %h exp 0", fifo_rdata_o); end
      n_cmp++; if (fifo_err_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_err: got %b exp 0", fifo_err_o); end
      step();
      idle_inputs();
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rel_busy: got %b exp 0", busy_o); end
      n_cmp++; if (fifo_addr_o !== 32'h0) begin n_err++; $display("FAIL rel_faddr: got %h exp 0", fifo_addr_o); end
      step();
      req_i = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL rel_req: got %b exp 1", instr_req_o); end
      n_cmp++; if (instr_addr_o !== 32'h0) begin n_err++; $display("FAIL rel_addr: got %h exp 0", instr_addr_o); end
      step();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      test_reset();
      test_stream();
      test_fifo_busy();
      test_branch();
      test_branch_pending();
      test_error();
      test_wrap_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
